// File: rtl/fp_mul_unpack_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fp_mul_unpack_stage : two-stage FP multiplier front end (sign, exponent sum, flags)
// Rev 1.0
// ----------------------------------------------------------------------------
module fp_mul_unpack_stage #(
  parameter int NB_MANT = 8,
  parameter int NB_EXP  = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  input  logic [NB_EXP+NB_MANT:0] OP_A,
  input  logic [NB_EXP+NB_MANT:0] OP_B,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic                    SIGN_C,
  output logic [NB_MANT-1:0]      MANT_A,
  output logic [NB_MANT-1:0]      MANT_B,
  output logic [NB_EXP-1:0]       EXP,
  output logic                    ZERO,
  output logic                    OVF,
  output logic                    UNF
);

  localparam int NB_SUM = NB_EXP + 2;
  localparam logic signed [NB_SUM-1:0] C_BIAS    = NB_SUM'((1 << (NB_EXP - 1)) - 1);
  localparam logic signed [NB_SUM-1:0] C_EXP_MAX = NB_SUM'((1 << NB_EXP) - 1);
  localparam logic signed [NB_SUM-1:0] C_ONE     = NB_SUM'(1);

  logic                    s1_valid;
  logic                    s2_valid;
  logic [NB_EXP+NB_MANT:0] s1_a;
  logic [NB_EXP+NB_MANT:0] s1_b;
  logic                    s1_adv;
  logic                    s2_adv;

  logic [NB_EXP-1:0]        ea;
  logic [NB_EXP-1:0]        eb;
  logic signed [NB_SUM-1:0] sum;
  logic                     nxt_sign;
  logic                     nxt_zero;
  logic                     nxt_ovf;
  logic                     nxt_unf;
  logic [NB_EXP-1:0]        nxt_exp;
  logic [NB_MANT-1:0]       nxt_ma;
  logic [NB_MANT-1:0]       nxt_mb;

  assign s2_adv    = !s2_valid || OUT_READY;
  assign s1_adv    = !s1_valid || s2_adv;
  assign IN_READY  = s1_adv && !RST;
  assign OUT_VALID = s2_valid;

  assign ea  = s1_a[NB_MANT +: NB_EXP];
  assign eb  = s1_b[NB_MANT +: NB_EXP];
  // Two guard bits keep the biased sum exact over the full operand range.
  assign sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - C_BIAS;

  always_comb begin
    nxt_sign = s1_a[NB_EXP+NB_MANT] ^ s1_b[NB_EXP+NB_MANT];
    nxt_zero = (ea == '0) || (eb == '0);
    nxt_ovf  = 1'b0;
    nxt_unf  = 1'b0;
    nxt_exp  = sum[NB_EXP-1:0];
    nxt_ma   = s1_a[NB_MANT-1:0];
    nxt_mb   = s1_b[NB_MANT-1:0];
    if (nxt_zero) begin
      nxt_exp = '0;
      nxt_ma  = '0;
      nxt_mb  = '0;
    end else if (sum > C_EXP_MAX) begin
      nxt_ovf = 1'b1;
      nxt_exp = '1;
    end else if (sum < C_ONE) begin
      nxt_unf = 1'b1;
      nxt_exp = '0;
    end
  end

  // Operand capture needs no reset; s1_valid qualifies it.
  always_ff @(posedge CLK) begin
    if (IN_VALID && s1_adv) begin
      s1_a <= OP_A;
      s1_b <= OP_B;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      SIGN_C   <= 1'b0;
      MANT_A   <= '0;
      MANT_B   <= '0;
      EXP      <= '0;
      ZERO     <= 1'b0;
      OVF      <= 1'b0;
      UNF      <= 1'b0;
    end else begin
      if (s1_adv) s1_valid <= IN_VALID;
      if (s2_adv) s2_valid <= s1_valid;
      if (s2_adv && s1_valid) begin
        SIGN_C <= nxt_sign;
        MANT_A <= nxt_ma;
        MANT_B <= nxt_mb;
        EXP    <= nxt_exp;
        ZERO   <= nxt_zero;
        OVF    <= nxt_ovf;
        UNF    <= nxt_unf;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_unpack_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fp_mul_unpack_stage : directed self-checking bench for fp_mul_unpack_stage
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_fp_mul_unpack_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic [12:0] OP_A;
  logic [12:0] OP_B;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic        SIGN_C;
  logic [7:0]  MANT_A;
  logic [7:0]  MANT_B;
  logic [3:0]  EXP;
  logic        ZERO;
  logic        OVF;
  logic        UNF;

  fp_mul_unpack_stage #(.NB_MANT(8), .NB_EXP(4)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OP_A(OP_A), .OP_B(OP_B), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .SIGN_C(SIGN_C), .MANT_A(MANT_A), .MANT_B(MANT_B), .EXP(EXP),
    .ZERO(ZERO), .OVF(OVF), .UNF(UNF)
  );

  always #5 CLK = ~CLK;

  // Result word: {sign, zero, ovf, unf, exp[3:0], mant_a[7:0], mant_b[7:0]}
  logic [23:0] res;
  assign res = {SIGN_C, ZERO, OVF, UNF, EXP, MANT_A, MANT_B};

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [23:0] model(input logic [12:0] a, input logic [12:0] b);
    int   ea;
    int   eb;
    int   s;
    logic sg;
    ea = int'(a[11:8]);
    eb = int'(b[11:8]);
    s  = ea + eb - 7;
    sg = a[12] ^ b[12];
    if (ea == 0 || eb == 0) return {sg, 3'b100, 4'h0, 16'h0000};
    if (s > 15)             return {sg, 3'b010, 4'hF, a[7:0], b[7:0]};
    if (s < 1)              return {sg, 3'b001, 4'h0, a[7:0], b[7:0]};
    return {sg, 3'b000, s[3:0], a[7:0], b[7:0]};
  endfunction

  // Scoreboard: expected results in acceptance order, plus hold-stable checking.
  logic [23:0] sb_q[$];
  logic [25:0] src_q[$];
  int          n_acc = 0;
  int          n_dlv = 0;
  logic        stalled = 1'b0;
  logic [23:0] held;

  always @(negedge CLK) begin
    if (RST) begin
      n_acc  -= sb_q.size();
      sb_q.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) check("hold_stable", 32'({OUT_VALID, res}), 32'({1'b1, held}));
      if (OUT_VALID) begin
        if (OUT_READY) begin
          if (sb_q.size() == 0) check("spurious_out", 32'(OUT_VALID), 0);
          else                  check("stream_result", 32'(res), 32'(sb_q.pop_front()));
          n_dlv++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = res;
        end
      end else begin
        stalled = 1'b0;
      end
      if (IN_VALID && IN_READY) begin
        sb_q.push_back(model(OP_A, OP_B));
        n_acc++;
      end
    end
  end

  task automatic run_one(input string tag, input logic [12:0] a, input logic [12:0] b,
                         input logic [23:0] want);
    @(posedge CLK); #1;
    IN_VALID = 1'b1; OP_A = a; OP_B = b; OUT_READY = 1'b1;
    @(negedge CLK); check({tag, "_in_ready"}, 32'(IN_READY), 1);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    @(negedge CLK); check({tag, "_lat1"}, 32'(OUT_VALID), 0);
    @(negedge CLK); check({tag, "_valid"}, 32'(OUT_VALID), 1);
    check(tag, 32'(res), 32'(want));
  endtask

  // mode 0: continuous valid, OUT_READY low for the first 6 cycles; mode 1: random both sides.
  task automatic stream(input int mode, input string tag);
    int   c = 0;
    int   sent = 0;
    int   n = src_q.size();
    logic took = 1'b1;
    while (sent < n && c < 400) begin
      @(posedge CLK); #1;
      OUT_READY = (mode == 0) ? (c >= 6) : ($urandom_range(0, 3) != 0);
      if (mode == 0)          IN_VALID = 1'b1;
      else if (took || !IN_VALID) IN_VALID = ($urandom_range(0, 2) != 0);
      {OP_A, OP_B} = src_q[sent];
      @(negedge CLK);
      if (mode == 0 && c == 1) check({tag, "_in_ready_c1"}, 32'(IN_READY), 1);
      if (mode == 0 && c == 2) check({tag, "_in_ready_drop"}, 32'(IN_READY), 0);
      took = IN_VALID && IN_READY;
      if (took) sent++;
      c++;
    end
    check({tag, "_all_sent"}, 32'(sent), 32'(n));
    @(posedge CLK); #1;
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    c = 0;
    while (sb_q.size() != 0 && c < 50) begin
      @(negedge CLK);
      c++;
    end
    @(negedge CLK);
    check({tag, "_drained"}, 32'(sb_q.size()), 0);
    check({tag, "_acc_eq_dlv"}, 32'(n_dlv), 32'(n_acc));
    src_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; IN_VALID = 1'b0; OP_A = '0; OP_B = '0; OUT_READY = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_out_valid", 32'(OUT_VALID), 0);
    check("rst_outputs", 32'(res), 0);
    check("rst_in_ready", 32'(IN_READY), 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("in_ready_after_rst", 32'(IN_READY), 1);

    run_one("basic",      13'h0780, 13'h0800, 24'h088000);
    run_one("sign_ovf",   13'h1F00, 13'h0FFF, 24'hAF00FF);
    run_one("unf",        13'h0112, 13'h0134, 24'h101234);
    run_one("zero_a",     13'h0055, 13'h1966, 24'hC00000);
    run_one("zero_b",     13'h15AA, 13'h0011, 24'hC00000);
    run_one("exp_max",    13'h0B01, 13'h1B02, 24'h8F0102);
    run_one("ovf_edge",   13'h0B00, 13'h0C00, 24'h2F0000);
    run_one("exp_min",    13'h0433, 13'h0444, 24'h013344);
    run_one("unf_edge",   13'h1400, 13'h1300, 24'h100000);

    src_q.push_back({13'h0780, 13'h0800});
    src_q.push_back({13'h1F00, 13'h0FFF});
    src_q.push_back({13'h0112, 13'h0134});
    src_q.push_back({13'h0055, 13'h1966});
    src_q.push_back({13'h0B01, 13'h1B02});
    src_q.push_back({13'h0433, 13'h0444});
    stream(0, "bp");

    @(posedge CLK); #1;
    OUT_READY = 1'b0; IN_VALID = 1'b1; OP_A = 13'h0780; OP_B = 13'h0800;
    @(posedge CLK); #1;
    OP_A = 13'h1F00; OP_B = 13'h0FFF;
    @(posedge CLK); #1;
    IN_VALID = 1'b0; RST = 1'b1;
    @(negedge CLK);
    check("midrst_in_ready_low", 32'(IN_READY), 0);
    @(posedge CLK); #1;
    RST = 1'b0; OUT_READY = 1'b1;
    @(negedge CLK);
    check("midrst_out_valid", 32'(OUT_VALID), 0);
    check("midrst_outputs", 32'(res), 0);
    check("midrst_in_ready", 32'(IN_READY), 1);
    run_one("post_rst", 13'h0433, 13'h0444, 24'h013344);

    for (int i = 0; i < 40; i++) src_q.push_back(26'($urandom));
    stream(1, "rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
